// File: rtl/mem_bus_ctrl.sv
// Core-facing memory/IO bus controller: posted-write buffer with read-after-write
// forwarding in front of a 256x16 synchronous RAM, plus LED/switch MMIO decode.
module mem_bus_ctrl #(
   parameter int         WBUF_DEPTH = 2,
   parameter logic [8:0] LED_ADDR   = 9'h100,
   parameter logic [8:0] SW_ADDR    = 9'h140
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  mem_cmd,
   input  logic [8:0]  mem_addr,
   input  logic [15:0] write_data,
   output logic [15:0] read_data,
   output logic        read_valid,
   output logic        wb_empty,
   output logic [7:0]  ram_addr,
   output logic        ram_we,
   output logic [15:0] ram_din,
   input  logic [15:0] ram_dout,
   input  logic [7:0]  sw,
   output logic [7:0]  led
);
   typedef enum logic [1:0] {SRC_ZERO, SRC_RAM, SRC_FWD} src_e;

   logic [7:0]  ent_addr_q [WBUF_DEPTH];
   logic [7:0]  ent_addr_d [WBUF_DEPTH];
   logic [15:0] ent_data_q [WBUF_DEPTH];
   logic [15:0] ent_data_d [WBUF_DEPTH];
   logic [2:0]  cnt_q, cnt_d;
   src_e        src_q;
   logic [15:0] fwd_q;
   logic        rvld_q;
   logic [7:0]  led_q;

   logic        is_read, is_write, is_ram, ram_rd, ram_wr, drain, hit;
   logic [15:0] hit_data;

   assign is_read  = (mem_cmd == 2'b01);
   assign is_write = (mem_cmd == 2'b10);
   assign is_ram   = !mem_addr[8];
   assign ram_rd   = is_read && is_ram;
   assign ram_wr   = is_write && is_ram;
   // A RAM read owns the port; reset suppresses draining so discarded entries never land
   assign drain    = !reset && !ram_rd && (cnt_q != 3'd0);

   // Entries are kept in age order (index 0 oldest), so the last match is the youngest
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      for (int i = 0; i < WBUF_DEPTH; i++) begin
         if ((3'(i) < cnt_q) && (ent_addr_q[i] == mem_addr[7:0])) begin
            hit      = 1'b1;
            hit_data = ent_data_q[i];
         end
      end
   end

   always_comb begin
      ent_addr_d = ent_addr_q;
      ent_data_d = ent_data_q;
      cnt_d      = cnt_q;
      if (drain) begin
         for (int i = 0; i < WBUF_DEPTH - 1; i++) begin
            ent_addr_d[i] = ent_addr_q[i+1];
            ent_data_d[i] = ent_data_q[i+1];
         end
         cnt_d = cnt_q - 3'd1;
      end
      // A write cycle never carries a RAM read, so a full buffer always drains here first
      if (ram_wr) begin
         for (int i = 0; i < WBUF_DEPTH; i++) begin
            if (3'(i) == cnt_d) begin
               ent_addr_d[i] = mem_addr[7:0];
               ent_data_d[i] = write_data;
            end
         end
         cnt_d = cnt_d + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      ent_addr_q <= ent_addr_d;
      ent_data_q <= ent_data_d;
      if (is_read) begin
         if (is_ram) fwd_q <= hit_data;
         else        fwd_q <= {8'h00, sw};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= 3'd0;
         src_q  <= SRC_ZERO;
         rvld_q <= 1'b0;
         led_q  <= 8'h00;
      end else begin
         cnt_q  <= cnt_d;
         rvld_q <= is_read;
         if (is_read) begin
            if (is_ram)                src_q <= hit ? SRC_FWD : SRC_RAM;
            else if (mem_addr == SW_ADDR) src_q <= SRC_FWD;
            else                       src_q <= SRC_ZERO;
         end
         if (is_write && (mem_addr == LED_ADDR)) led_q <= write_data[7:0];
      end
   end

   always_comb begin
      case (src_q)
         SRC_RAM: read_data = ram_dout;
         SRC_FWD: read_data = fwd_q;
         default: read_data = 16'h0000;
      endcase
   end

   assign read_valid = rvld_q;
   assign wb_empty   = (cnt_q == 3'd0);
   assign ram_we     = drain;
   assign ram_addr   = drain ? ent_addr_q[0] : mem_addr[7:0];
   assign ram_din    = ent_data_q[0];
   assign led        = led_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of the posted-write buffer and memory image.
module tb_mem_bus_ctrl;
   localparam int DEPTH = 2;
   localparam logic [1:0] C_NONE = 2'b00, C_RD = 2'b01, C_WR = 2'b10;

   logic        clk, reset;
   logic [1:0]  mem_cmd;
   logic [8:0]  mem_addr;
   logic [15:0] write_data, read_data, ram_din, ram_dout;
   logic        read_valid, wb_empty, ram_we;
   logic [7:0]  ram_addr, sw, led;

   mem_bus_ctrl #(.WBUF_DEPTH(DEPTH), .LED_ADDR(9'h100), .SW_ADDR(9'h140)) dut (
      .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
      .write_data(write_data), .read_data(read_data), .read_valid(read_valid),
      .wb_empty(wb_empty), .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
      .ram_dout(ram_dout), .sw(sw), .led(led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous RAM device attached to the controller
   logic [15:0] ram_mem [256];
   always @(posedge clk) begin
      if (ram_we) ram_mem[ram_addr] <= ram_din;
      ram_dout <= ram_mem[ram_addr];
   end

   // Model: pending writes in program order, plus the image the RAM should hold
   typedef struct {logic [7:0] a; logic [15:0] d;} ent_t;
   ent_t        q[$];
   logic [15:0] shadow [256];
   logic        exp_rvld;
   logic [15:0] exp_rdata;
   logic [7:0]  exp_led;
   bit          chk_en;
   int          checks, errors;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] predict(input logic [8:0] a, input logic [7:0] s);
      logic [15:0] v;
      if (!a[8]) begin
         v = shadow[a[7:0]];
         foreach (q[i]) if (q[i].a == a[7:0]) v = q[i].d;
      end else if (a == 9'h140) v = {8'h00, s};
      else v = 16'h0000;
      return v;
   endfunction

   function automatic bit exp_drain();
      return !reset && !((mem_cmd == C_RD) && !mem_addr[8]) && (q.size() != 0);
   endfunction

   task automatic compare();
      bit we_e;
      we_e = exp_drain();
      chk("ram_we", 16'(ram_we), 16'(we_e));
      if (we_e) begin
         chk("ram_addr_drain", 16'(ram_addr), 16'(q[0].a));
         chk("ram_din", ram_din, q[0].d);
      end else if ((mem_cmd == C_RD) && !mem_addr[8]) begin
         chk("ram_addr_read", 16'(ram_addr), 16'(mem_addr[7:0]));
      end
      chk("wb_empty", 16'(wb_empty), 16'(q.size() == 0));
      chk("read_valid", 16'(read_valid), 16'(exp_rvld));
      if (exp_rvld) chk("read_data", read_data, exp_rdata);
      chk("led", 16'(led), 16'(exp_led));
   endtask

   task automatic model_edge();
      bit we_e;
      we_e = exp_drain();
      if (reset) begin
         q.delete();
         exp_led  = 8'h00;
         exp_rvld = 1'b0;
      end else begin
         exp_rvld = (mem_cmd == C_RD);
         if (mem_cmd == C_RD) exp_rdata = predict(mem_addr, sw);
         if (we_e) begin
            shadow[q[0].a] = q[0].d;
            void'(q.pop_front());
         end
         if ((mem_cmd == C_WR) && !mem_addr[8]) q.push_back('{mem_addr[7:0], write_data});
         if ((mem_cmd == C_WR) && (mem_addr == 9'h100)) exp_led = write_data[7:0];
      end
   endtask

   task automatic step(input logic r, input logic [1:0] c, input logic [8:0] a,
                       input logic [15:0] d, input logic [7:0] s);
      @(negedge clk);
      reset = r; mem_cmd = c; mem_addr = a; write_data = d; sw = s;
      #2;
      if (chk_en) compare();
      model_edge();
   endtask

   initial begin
      logic [8:0] a;
      logic [1:0] c;
      checks = 0; errors = 0; chk_en = 0;
      exp_rvld = 0; exp_rdata = 0; exp_led = 0;
      for (int i = 0; i < 256; i++) begin
         ram_mem[i] = 16'(i * 37) ^ 16'hA5A5;
         shadow[i]  = 16'(i * 37) ^ 16'hA5A5;
      end
      reset = 1; mem_cmd = C_NONE; mem_addr = 0; write_data = 0; sw = 0;

      step(1, C_NONE, 0, 0, 0);
      chk_en = 1;
      step(1, C_NONE, 0, 0, 0);
      step(0, C_NONE, 0, 0, 0);
      chk("rst_read_valid", 16'(read_valid), 16'h0);
      chk("rst_read_data", read_data, 16'h0000);
      chk("rst_wb_empty", 16'(wb_empty), 16'h1);
      chk("rst_led", 16'(led), 16'h00);
      chk("rst_ram_we", 16'(ram_we), 16'h0);

      // Forwarding
      step(0, C_WR, 9'h012, 16'hBEEF, 0);
      step(0, C_RD, 9'h012, 0, 0);
      step(0, C_NONE, 0, 0, 0);
      chk("fwd_valid", 16'(read_valid), 16'h1);
      chk("fwd_data", read_data, 16'hBEEF);

      // Drain on idle
      step(0, C_WR, 9'h005, 16'h1234, 0);
      step(0, C_NONE, 0, 0, 0);
      chk("drain_we", 16'(ram_we), 16'h1);
      chk("drain_addr", 16'(ram_addr), 16'h0005);
      chk("drain_din", ram_din, 16'h1234);
      step(0, C_NONE, 0, 0, 0);
      chk("drain_empty", 16'(wb_empty), 16'h1);
      step(0, C_RD, 9'h005, 0, 0);
      step(0, C_NONE, 0, 0, 0);
      chk("drain_readback", read_data, 16'h1234);

      // Writes interleaved with reads, then idle and read back
      step(0, C_WR, 9'h001, 16'hAAAA, 0);
      step(0, C_RD, 9'h033, 0, 0);
      step(0, C_WR, 9'h002, 16'hBBBB, 0);
      step(0, C_RD, 9'h034, 0, 0);
      step(0, C_WR, 9'h003, 16'hCCCC, 0);
      repeat (3) step(0, C_NONE, 0, 0, 0);
      chk("full_empty", 16'(wb_empty), 16'h1);
      chk("full_ramA", ram_mem[1], 16'hAAAA);
      chk("full_ramB", ram_mem[2], 16'hBBBB);
      chk("full_ramC", ram_mem[3], 16'hCCCC);

      // Youngest wins
      step(0, C_WR, 9'h020, 16'h0001, 0);
      step(0, C_WR, 9'h020, 16'h0002, 0);
      step(0, C_RD, 9'h020, 0, 0);
      step(0, C_NONE, 0, 0, 0);
      chk("youngest", read_data, 16'h0002);
      repeat (2) step(0, C_NONE, 0, 0, 0);

      // MMIO
      step(0, C_WR, 9'h100, 16'hFFA5, 0);
      chk("led_no_we", 16'(ram_we), 16'h0);
      step(0, C_NONE, 0, 0, 0);
      chk("led_val", 16'(led), 16'h00A5);
      step(0, C_RD, 9'h140, 0, 8'h3C);
      step(0, C_RD, 9'h1FF, 0, 8'h00);
      chk("sw_read", read_data, 16'h003C);
      step(0, C_WR, 9'h1AB, 16'h7777, 0);
      chk("unmapped_read", read_data, 16'h0000);
      step(0, C_NONE, 0, 0, 0);
      chk("unmapped_wr_drop", 16'(wb_empty), 16'h1);

      // Reset mid-operation
      step(0, C_WR, 9'h030, 16'h1111, 0);
      step(0, C_RD, 9'h040, 0, 0);
      step(0, C_WR, 9'h031, 16'h2222, 0);
      step(1, C_NONE, 0, 0, 0);
      chk("rst_mid_no_we", 16'(ram_we), 16'h0);
      step(0, C_NONE, 0, 0, 0);
      chk("rst_mid_empty", 16'(wb_empty), 16'h1);
      chk("rst_mid_led", 16'(led), 16'h00);
      chk("rst_mid_ram", ram_mem[8'h31], 16'(8'h31 * 37) ^ 16'hA5A5);

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         case ($urandom_range(0, 9))
            0:       a = 9'h100;
            1:       a = 9'h140;
            2:       a = 9'h1FF;
            3:       a = 9'h1AB;
            default: a = 9'($urandom_range(0, 7));
         endcase
         c = 2'($urandom_range(0, 3));
         step(($urandom_range(0, 63) == 0), c, a, 16'($urandom), 8'($urandom));
      end
      repeat (3) step(0, C_NONE, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
